// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares the AXI AR/R read channel between instruction fetch and data load.
// Define AXI_RD_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over inst.
//   state | meaning
//   IDLE  | AR slot empty, one eligible requester may be granted
//   BUSY  | AR beat presented, arvalid held until arready
module axi_rd_arbiter #(
  parameter logic [3:0] INST_ID = 4'h0,
  parameter logic [3:0] DATA_ID = 4'h1,
  parameter int         MAX_OUT = 4,
  parameter int         CNT_W   = 4
) (
  input  logic        aclk,
  input  logic        areset,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [1:0]  inst_size,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_size,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  input  logic        wr_busy,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        rid_err
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] inst_cnt;
  logic [CNT_W-1:0] data_cnt;
  logic [31:0]      inst_rdata_q;
  logic [31:0]      data_rdata_q;

  logic inst_elig;
  logic data_elig;
  logic grant_inst;
  logic grant_data;
  logic inst_hit;
  logic data_hit;
  logic inst_ret;
  logic data_ret;

  always_comb begin
    inst_elig = inst_req && (inst_cnt != CNT_MAX);
    data_elig = data_req && !wr_busy && (data_cnt != CNT_MAX);
  end

`ifdef AXI_RD_ARB_RR_EN
  // 1 when data took the most recent grant; reset value lets data win first
  logic last_grant;

  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (state == IDLE) begin
      if (inst_elig && data_elig) begin
        grant_data = !last_grant;
        grant_inst = last_grant;
      end else begin
        grant_inst = inst_elig;
        grant_data = data_elig;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      last_grant <= 1'b0;
    end else if (grant_data) begin
      last_grant <= 1'b1;
    end else if (grant_inst) begin
      last_grant <= 1'b0;
    end
  end
`else
  always_comb begin
    grant_data = (state == IDLE) && data_elig;
    grant_inst = (state == IDLE) && inst_elig && !data_elig;
  end
`endif

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;

  // AR slot: request latched on grant, released on handshake; no same-cycle refill
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state   <= IDLE;
      arvalid <= 1'b0;
      arid    <= 4'h0;
      araddr  <= 32'h0;
      arsize  <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (grant_data) begin
            state   <= BUSY;
            arvalid <= 1'b1;
            arid    <= DATA_ID;
            araddr  <= data_addr;
            arsize  <= {1'b0, data_size};
          end else if (grant_inst) begin
            state   <= BUSY;
            arvalid <= 1'b1;
            arid    <= INST_ID;
            araddr  <= inst_addr;
            arsize  <= {1'b0, inst_size};
          end
        end
        BUSY: begin
          if (arready) begin
            state   <= IDLE;
            arvalid <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          arvalid <= 1'b0;
        end
      endcase
    end
  end

  // A beat is only accepted for an ID that still has a read in flight
  always_comb begin
    inst_hit = rvalid && (rid == INST_ID) && (inst_cnt != '0);
    data_hit = rvalid && (rid == DATA_ID) && (data_cnt != '0);
    inst_ret = inst_hit && rlast;
    data_ret = data_hit && rlast;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      inst_cnt <= '0;
      data_cnt <= '0;
    end else begin
      case ({grant_inst, inst_ret})
        2'b10:   inst_cnt <= inst_cnt + CNT_ONE;
        2'b01:   inst_cnt <= inst_cnt - CNT_ONE;
        default: inst_cnt <= inst_cnt;
      endcase
      case ({grant_data, data_ret})
        2'b10:   data_cnt <= data_cnt + CNT_ONE;
        2'b01:   data_cnt <= data_cnt - CNT_ONE;
        default: data_cnt <= data_cnt;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
      rid_err      <= 1'b0;
    end else begin
      if (inst_hit) begin
        inst_rdata_q <= rdata;
      end
      if (data_hit) begin
        data_rdata_q <= rdata;
      end
      if (rvalid && !inst_hit && !data_hit) begin
        rid_err <= 1'b1;
      end
    end
  end

  assign inst_data_ok = inst_hit;
  assign data_data_ok = data_hit;
  assign inst_rdata   = inst_hit ? rdata : inst_rdata_q;
  assign data_rdata   = data_hit ? rdata : data_rdata_q;
  assign rready       = 1'b1;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: per-cycle vector table for axi_rd_arbiter plus an AR scoreboard.
// Arbitration expectations follow AXI_RD_ARB_RR_EN when the bench is built with it.
module tb_axi_rd_arbiter;

  localparam logic [3:0] INST_ID = 4'h0;
  localparam logic [3:0] DATA_ID = 4'h1;

  logic        aclk;
  logic        areset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [1:0]  inst_size;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [31:0] data_addr;
  logic [1:0]  data_size;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        wr_busy;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        rid_err;

  axi_rd_arbiter #(
    .INST_ID(INST_ID),
    .DATA_ID(DATA_ID),
    .MAX_OUT(4),
    .CNT_W  (4)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_size   (inst_size),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_addr   (data_addr),
    .data_size   (data_size),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata),
    .wr_busy     (wr_busy),
    .arid        (arid),
    .araddr      (araddr),
    .arsize      (arsize),
    .arvalid     (arvalid),
    .arready     (arready),
    .rid         (rid),
    .rdata       (rdata),
    .rlast       (rlast),
    .rvalid      (rvalid),
    .rready      (rready),
    .rid_err     (rid_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic        ireq, dreq, wb, ardy, rv;
    logic [3:0]  rid;
    logic        rl;
    logic [31:0] rd;
    logic        iok, dok, idok, ddok, arv, err;
  } vec_t;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  size;
  } ar_t;

  vec_t vecs[$];
  ar_t  ar_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vidx   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, vidx, act, exp);
    end
  endtask

  // c = {ireq,dreq,wr_busy,arready,rvalid}; x = {iok,dok,idok,ddok,arvalid,rid_err}
  task automatic add(input logic [4:0] c, input logic [3:0] r_id, input logic r_last,
                     input logic [31:0] r_data, input logic [5:0] x);
    vec_t v;
    v.ireq = c[4]; v.dreq = c[3]; v.wb = c[2]; v.ardy = c[1]; v.rv = c[0];
    v.rid  = r_id; v.rl = r_last; v.rd = r_data;
    v.iok  = x[5]; v.dok = x[4]; v.idok = x[3]; v.ddok = x[2]; v.arv = x[1]; v.err = x[0];
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    ar_t e;
    @(negedge aclk);
    inst_req  = v.ireq;
    data_req  = v.dreq;
    wr_busy   = v.wb;
    arready   = v.ardy;
    rvalid    = v.rv;
    rid       = v.rid;
    rlast     = v.rl;
    rdata     = v.rd;
    inst_addr = 32'h1c00_0000 + 32'(vidx * 4);
    inst_size = 2'd2;
    data_addr = 32'h8000_0000 + 32'(vidx * 16);
    data_size = 2'(vidx);
    #2;
    chk("inst_addr_ok", 32'(inst_addr_ok), 32'(v.iok));
    chk("data_addr_ok", 32'(data_addr_ok), 32'(v.dok));
    chk("inst_data_ok", 32'(inst_data_ok), 32'(v.idok));
    chk("data_data_ok", 32'(data_data_ok), 32'(v.ddok));
    chk("arvalid", 32'(arvalid), 32'(v.arv));
    chk("rid_err", 32'(rid_err), 32'(v.err));
    if (v.idok) chk("inst_rdata", inst_rdata, v.rd);
    if (v.ddok) chk("data_rdata", data_rdata, v.rd);
    if (arvalid && arready) begin
      if (ar_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ar_unexpected vec=%0d actual=%h required=none", vidx, araddr);
      end else begin
        e = ar_q.pop_front();
        chk("arid", 32'(arid), 32'(e.id));
        chk("araddr", araddr, e.addr);
        chk("arsize", 32'(arsize), 32'(e.size));
      end
    end
    if (v.iok) begin
      e.id = INST_ID; e.addr = inst_addr; e.size = {1'b0, inst_size};
      ar_q.push_back(e);
    end
    if (v.dok) begin
      e.id = DATA_ID; e.addr = data_addr; e.size = {1'b0, data_size};
      ar_q.push_back(e);
    end
    vidx++;
  endtask

  task automatic run_all();
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    areset = 1'b1;
    inst_req = 1'b0; inst_addr = 32'h0; inst_size = 2'd0;
    data_req = 1'b0; data_addr = 32'h0; data_size = 2'd0;
    wr_busy = 1'b0; arready = 1'b0;
    rid = 4'h0; rdata = 32'h0; rlast = 1'b0; rvalid = 1'b0;

    #1;
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_arid", 32'(arid), 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_arsize", 32'(arsize), 32'd0);
    chk("rst_rid_err", 32'(rid_err), 32'd0);
    chk("rready", 32'(rready), 32'd1);
    @(negedge aclk);
    areset = 1'b0;

    // both requesters saturating with arready=1: 8 grants, one every 2 cycles
    for (int k = 0; k < 16; k++) begin
      logic gd;
`ifdef AXI_RD_ARB_RR_EN
      gd = ((k / 2) % 2) == 0;
`else
      gd = (k < 8);
`endif
      if ((k % 2) == 0) add(5'b11010, 4'h0, 1'b0, 32'h0, {~gd, gd, 4'b0000});
      else              add(5'b11010, 4'h0, 1'b0, 32'h0, 6'b000010);
    end
    // both counters at MAX_OUT: blocked until one inst response returns
    add(5'b11010, 4'h0,    1'b0, 32'h0,         6'b000000);
    add(5'b11001, INST_ID, 1'b1, 32'h1111_0000, 6'b001000);
    add(5'b11000, 4'h0,    1'b0, 32'h0,         6'b100000);
    add(5'b00010, 4'h0,    1'b0, 32'h0,         6'b000010);
    for (int k = 0; k < 4; k++) add(5'b00001, DATA_ID, 1'b1, 32'hD000_0000 + 32'(k), 6'b000100);
    for (int k = 0; k < 4; k++) add(5'b00001, INST_ID, 1'b1, 32'h1000_0000 + 32'(k), 6'b001000);
    // single inst read
    add(5'b00000, 4'h0,    1'b0, 32'h0,         6'b000000);
    add(5'b10000, 4'h0,    1'b0, 32'h0,         6'b100000);
    add(5'b00010, 4'h0,    1'b0, 32'h0,         6'b000010);
    add(5'b00001, INST_ID, 1'b1, 32'hDEAD_BEEF, 6'b001000);
    add(5'b00000, 4'h0,    1'b0, 32'h0,         6'b000000);
    // wr_busy blocks data; non-last beat delivers without retiring
    add(5'b01100, 4'h0,    1'b0, 32'h0,         6'b000000);
    add(5'b01100, 4'h0,    1'b0, 32'h0,         6'b000000);
    add(5'b01000, 4'h0,    1'b0, 32'h0,         6'b010000);
    add(5'b00010, 4'h0,    1'b0, 32'h0,         6'b000010);
    add(5'b00001, DATA_ID, 1'b0, 32'hA5A5_0001, 6'b000100);
    add(5'b00001, DATA_ID, 1'b1, 32'hCAFE_F00D, 6'b000100);
    // unknown rid, then a valid beat, then a beat with the counter at 0
    add(5'b10000, 4'h0,    1'b0, 32'h0,         6'b100000);
    add(5'b00010, 4'h0,    1'b0, 32'h0,         6'b000010);
    add(5'b00001, 4'h5,    1'b1, 32'h5555_5555, 6'b000000);
    add(5'b00001, INST_ID, 1'b1, 32'hFEED_FACE, 6'b001001);
    add(5'b00001, INST_ID, 1'b1, 32'h0BAD_BAD0, 6'b000001);
    add(5'b00000, 4'h0,    1'b0, 32'h0,         6'b000001);
    run_all();

    chk("inst_rdata_hold", inst_rdata, 32'hFEED_FACE);
    chk("data_rdata_hold", data_rdata, 32'hCAFE_F00D);

    // two data reads outstanding, second AR still pending when reset hits
    add(5'b01000, 4'h0, 1'b0, 32'h0, 6'b010001);
    add(5'b00010, 4'h0, 1'b0, 32'h0, 6'b000011);
    add(5'b01000, 4'h0, 1'b0, 32'h0, 6'b010001);
    add(5'b00000, 4'h0, 1'b0, 32'h0, 6'b000011);
    run_all();
    areset = 1'b1;
    #1;
    chk("mid_rst_arvalid", 32'(arvalid), 32'd0);
    chk("mid_rst_araddr", araddr, 32'd0);
    chk("mid_rst_rid_err", 32'(rid_err), 32'd0);
    ar_q.delete();
    @(negedge aclk);
    areset = 1'b0;

    add(5'b00001, DATA_ID, 1'b1, 32'h1234_5678, 6'b000000);
    add(5'b00001, INST_ID, 1'b1, 32'h9ABC_DEF0, 6'b000001);
    add(5'b10000, 4'h0,    1'b0, 32'h0,         6'b100001);
    add(5'b00010, 4'h0,    1'b0, 32'h0,         6'b000011);
    add(5'b00001, INST_ID, 1'b1, 32'h600D_F00D, 6'b001001);
    add(5'b00000, 4'h0,    1'b0, 32'h0,         6'b000001);
    run_all();

    chk("ar_q_drained", 32'(ar_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
